// File: rtl/muladd_pkg.sv
// Shared defaults and helpers for the pipelined multiply-add that rebuilds
// a dividend from a divider's quotient/remainder.
package muladd_pkg;

  localparam int unsigned DEF_DIVIDEND = 4;
  localparam int unsigned DEF_DIVISOR  = 2;
  localparam int unsigned FLAG_W       = 32;

  // A (divisor, remainder) pair that no divider could have produced.
  function automatic logic is_rem_invalid(input logic [FLAG_W-1:0] divisor,
                                          input logic [FLAG_W-1:0] remainder);
    return (divisor == '0) || (remainder >= divisor);
  endfunction

endpackage

// File: rtl/muladd_stage.sv
// One partial-product stage: adds divisor<<BIT when quotient bit BIT is set,
// forwarding everything else; holds while advance is low.
module muladd_stage #(
  parameter int unsigned DIVIDEND = 4,
  parameter int unsigned DIVISOR  = 2,
  parameter int unsigned BIT      = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          advance,
  input  logic                          prev_valid,
  input  logic [DIVIDEND+DIVISOR-1:0]   prev_acc,
  input  logic [DIVIDEND-1:0]           prev_qbits,
  input  logic [DIVISOR-1:0]            prev_divisor,
  input  logic                          prev_rem_invalid,
  output logic                          valid,
  output logic [DIVIDEND+DIVISOR-1:0]   acc,
  output logic [DIVIDEND-1:0]           qbits,
  output logic [DIVISOR-1:0]            divisor,
  output logic                          rem_invalid
);

  localparam int unsigned ACC_W = DIVIDEND + DIVISOR;

  logic [ACC_W-1:0] addend_c;

  // Partial product for this stage's quotient bit.
  always_comb begin
    addend_c = '0;
    if (prev_qbits[BIT]) begin
      addend_c = ACC_W'(prev_divisor) << BIT;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid       <= 1'b0;
      acc         <= '0;
      qbits       <= '0;
      divisor     <= '0;
      rem_invalid <= 1'b0;
    end else if (advance) begin
      valid       <= prev_valid;
      acc         <= prev_acc + addend_c;
      qbits       <= prev_qbits;
      divisor     <= prev_divisor;
      rem_invalid <= prev_rem_invalid;
    end
  end

endmodule

// File: rtl/pipelined_muladd.sv
// Streaming dividend = quotient*divisor + remainder, one register stage per
// quotient bit, with a single global advance for backpressure.
module pipelined_muladd
  import muladd_pkg::*;
#(
  parameter int unsigned DIVIDEND = DEF_DIVIDEND,
  parameter int unsigned DIVISOR  = DEF_DIVISOR
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIVIDEND-1:0] quotient,
  input  logic [DIVISOR-1:0]  divisor,
  input  logic [DIVISOR-1:0]  remainder,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIVIDEND-1:0] dividend,
  output logic                overflow,
  output logic                rem_invalid
);

  // Wide enough for the largest q*d+r, so no stage ever truncates.
  localparam int unsigned ACC_W = DIVIDEND + DIVISOR;

  typedef struct packed {
    logic                valid;
    logic [ACC_W-1:0]    acc;
    logic [DIVIDEND-1:0] qbits;
    logic [DIVISOR-1:0]  divisor;
    logic                rem_invalid;
  } stage_t;

  // pipe[0] is the input view; pipe[k] is the output of register stage k.
  stage_t pipe [DIVIDEND+1];
  logic   advance;

  assign advance  = !pipe[DIVIDEND].valid || out_ready;
  assign in_ready = advance;

  assign pipe[0] = {in_valid, ACC_W'(remainder), quotient, divisor,
                    is_rem_invalid(FLAG_W'(divisor), FLAG_W'(remainder))};

  for (genvar i = 0; i < DIVIDEND; i++) begin : g_stage
    logic                valid;
    logic [ACC_W-1:0]    acc;
    logic [DIVIDEND-1:0] qbits;
    logic [DIVISOR-1:0]  dvsr;
    logic                rinv;

    muladd_stage #(
      .DIVIDEND (DIVIDEND),
      .DIVISOR  (DIVISOR),
      .BIT      (i)
    ) u_stage (
      .clock            (clock),
      .reset_n          (reset_n),
      .advance          (advance),
      .prev_valid       (pipe[i].valid),
      .prev_acc         (pipe[i].acc),
      .prev_qbits       (pipe[i].qbits),
      .prev_divisor     (pipe[i].divisor),
      .prev_rem_invalid (pipe[i].rem_invalid),
      .valid            (valid),
      .acc              (acc),
      .qbits            (qbits),
      .divisor          (dvsr),
      .rem_invalid      (rinv)
    );

    assign pipe[i+1] = {valid, acc, qbits, dvsr, rinv};
  end

  assign out_valid   = pipe[DIVIDEND].valid;
  assign dividend    = pipe[DIVIDEND].acc[DIVIDEND-1:0];
  assign overflow    = |pipe[DIVIDEND].acc[ACC_W-1:DIVIDEND];
  assign rem_invalid = pipe[DIVIDEND].rem_invalid;

  // Operands carried to the last stage have no further consumer.
  logic unused_tail;
  assign unused_tail = ^{pipe[DIVIDEND].qbits, pipe[DIVIDEND].divisor};

endmodule

// File: tb/tb_pipelined_muladd.sv
// Scoreboard bench for pipelined_muladd: reference model q*d+r in plain integers.
module tb_pipelined_muladd;

  localparam int DIVIDEND = 4;
  localparam int DIVISOR  = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] quotient = '0;
  logic [1:0] divisor = '0;
  logic [1:0] remainder = '0;
  logic       in_ready, out_valid, overflow, rem_invalid;
  logic [3:0] dividend;

  typedef struct {
    int dividend;
    int overflow;
    int rem_invalid;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   lat_check = 1'b1;
  bit   prev_stall = 1'b0;
  int   prev_div, prev_ovf, prev_ri;

  pipelined_muladd #(.DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .quotient    (quotient),
    .divisor     (divisor),
    .remainder   (remainder),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dividend    (dividend),
    .overflow    (overflow),
    .rem_invalid (rem_invalid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer multiply-add and divider-legality rule.
  function automatic exp_t model(input int q, input int d, input int r, input int c);
    exp_t x;
    int full;
    full          = q * d + r;
    x.dividend    = full % (1 << DIVIDEND);
    x.overflow    = (full >= (1 << DIVIDEND)) ? 1 : 0;
    x.rem_invalid = (d == 0 || r >= d) ? 1 : 0;
    x.cyc         = c;
    return x;
  endfunction

  // Monitor: handshakes seen here complete at the following rising edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", int'(in_ready), 0);
        if (prev_stall) begin
          chk("stall_hold_dividend", int'(dividend), prev_div);
          chk("stall_hold_overflow", int'(overflow), prev_ovf);
          chk("stall_hold_rem_invalid", int'(rem_invalid), prev_ri);
        end
        prev_stall = 1'b1;
        prev_div   = int'(dividend);
        prev_ovf   = int'(overflow);
        prev_ri    = int'(rem_invalid);
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", int'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("dividend", int'(dividend), e.dividend);
          chk("overflow", int'(overflow), e.overflow);
          chk("rem_invalid", int'(rem_invalid), e.rem_invalid);
          if (lat_check) chk("latency", cyc - e.cyc, DIVIDEND);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(int'(quotient), int'(divisor), int'(remainder), cyc));
        n_vec++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input bit v, input int q, input int d, input int r);
    in_valid  = v;
    quotient  = 4'(q);
    divisor   = 2'(d);
    remainder = 2'(r);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int waited;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waited    = 0;
    while (sb.size() != 0 && waited < 40) begin
      step();
      waited++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_dividend", int'(dividend), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_rem_invalid", int'(rem_invalid), 0);
    step();
    step();
    reset_n = 1'b1;
    chk("post_reset_in_ready", int'(in_ready), 1);

    // Single transaction, then probe the output directly after 4 edges.
    send(1, 4, 3, 2);
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("single_out_valid", int'(out_valid), 1);
    chk("single_dividend", int'(dividend), 14);
    idle(4);

    send(1, 15, 3, 2);
    idle(5);
    send(1, 3, 0, 1);
    send(1, 2, 2, 3);
    idle(6);

    // Round trip of every legal dividend/divisor pair, back-to-back.
    for (int dv = 1; dv < 4; dv++) begin
      for (int dd = 0; dd < 16; dd++) begin
        send(1, dd / dv, dv, dd % dv);
        chk("roundtrip_in_ready", int'(in_ready), 1);
      end
    end
    idle(6);

    // Backpressure with a full pipeline.
    lat_check = 1'b0;
    for (int i = 0; i < 6; i++) send(1, $urandom_range(0, 15), $urandom_range(1, 3), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(1, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 3),
           $urandom_range(0, 3));
    end
    drain();

    // Reset with transactions in flight.
    lat_check = 1'b1;
    for (int i = 0; i < 5; i++) send(1, 15 - i, 3, 2);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_dividend", int'(dividend), 0);
    chk("midreset_overflow", int'(overflow), 0);
    chk("midreset_rem_invalid", int'(rem_invalid), 0);
    step();
    step();
    reset_n = 1'b1;
    chk("midreset_in_ready", int'(in_ready), 1);
    idle(6);
    chk("midreset_quiet", int'(out_valid), 0);
    send(1, 5, 2, 1);
    idle(6);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
